sensor_ctrl: RTL and testbench

//  Sensor controller downstream of the sensor AHB slave wrapper (S4). Captures samples from an

---
 rtl/sctrl_pkg.sv | 19 +
 rtl/sctrl_buf.sv | 40 ++++
 rtl/sensor_ctrl.sv | 142 ++++++++++++++
 tb/tb_sensor_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sctrl_pkg.sv
// Shared types and sizing for the sensor capture controller.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package sctrl_pkg;

    // Controller modes: waiting for enable, taking samples, holding a full buffer.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } sctrl_state_e;

    localparam int SCTRL_DEPTH  = 64;
    localparam int SCTRL_ADDR_W = 6;
    localparam int SCTRL_DATA_W = `DATA_SIZE;

endpackage

// File: rtl/sctrl_buf.sv
// Sample buffer: one synchronous write port and one registered read port.
// A read and a write to the same index in one cycle return the previous contents.
module sctrl_buf
    import sctrl_pkg::*;
#(
    parameter int DATA_W = SCTRL_DATA_W,
    parameter int DEPTH  = SCTRL_DEPTH,
    parameter int ADDR_W = SCTRL_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Store an accepted sample; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read; sampling the array before the write lands gives old-data-on-collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= '0;
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/sensor_ctrl.sv
// Sensor capture controller: fills the sample buffer while enabled, raises the
// interrupt once every slot holds a fresh sample, and rearms on a clear pulse.
module sensor_ctrl
    import sctrl_pkg::*;
#(
    parameter int DATA_W = SCTRL_DATA_W,
    parameter int DEPTH  = SCTRL_DEPTH,
    parameter int ADDR_W = SCTRL_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sctrl_en,
    input  logic              sctrl_clear,
    input  logic [ADDR_W-1:0] sctrl_addr,
    output logic [DATA_W-1:0] sctrl_out,
    output logic              sctrl_interrupt,
    input  logic              sensor_ready,
    input  logic [DATA_W-1:0] sensor_out,
    output logic              sensor_en
);

    sctrl_state_e      state_r;
    sctrl_state_e      state_next_s;
    logic [ADDR_W-1:0] wr_cnt_r;
    logic              wr_en_s;
    logic              buf_we_s;
    logic              sensor_en_s;
    logic              interrupt_s;
    logic              sensor_en_r;
    logic              interrupt_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and sample-accept decode; a clear always wins over a pending sample.
    always_comb begin
        state_next_s = state_r;
        wr_en_s      = 1'b0;
        if (sctrl_clear) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sctrl_en) begin
                        state_next_s = CAPTURE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                CAPTURE: begin
                    if (sensor_ready) begin
                        wr_en_s = 1'b1;
                        if (wr_cnt_r == ADDR_W'(DEPTH - 1)) begin
                            state_next_s = FULL;
                        end else begin
                            state_next_s = CAPTURE;
                        end
                    end else if (!sctrl_en) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = CAPTURE;
                    end
                end
                FULL: begin
                    state_next_s = FULL;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // Outputs follow the upcoming state so they change on the same edge as the state.
    always_comb begin
        sensor_en_s = 1'b0;
        interrupt_s = 1'b0;
        case (state_next_s)
            CAPTURE: begin
                sensor_en_s = 1'b1;
            end
            FULL: begin
                interrupt_s = 1'b1;
            end
            default: begin
                sensor_en_s = 1'b0;
                interrupt_s = 1'b0;
            end
        endcase
    end

    // Registered copies of the handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sensor_en_r <= 1'b0;
            interrupt_r <= 1'b0;
        end else begin
            sensor_en_r <= sensor_en_s;
            interrupt_r <= interrupt_s;
        end
    end

    // Write pointer: wraps naturally at DEPTH, kept across pauses, zeroed by clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r <= '0;
        end else if (sctrl_clear) begin
            wr_cnt_r <= '0;
        end else if (wr_en_s) begin
            wr_cnt_r <= wr_cnt_r + ADDR_W'(1);
        end else begin
            wr_cnt_r <= wr_cnt_r;
        end
    end

    // No sample is stored on a reset edge.
    assign buf_we_s = wr_en_s & ~rst;

    sctrl_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_we_s),
        .wr_addr (wr_cnt_r),
        .wr_data (sensor_out),
        .rd_addr (sctrl_addr),
        .rd_data (sctrl_out)
    );

    assign sensor_en       = sensor_en_r;
    assign sctrl_interrupt = interrupt_r;

endmodule

// File: tb/tb_sensor_ctrl.sv
// Self-checking bench for sensor_ctrl: directed scenarios plus random traffic,
// each cycle compared against a behavioural model of the capture buffer.
module tb_sensor_ctrl;

    logic        clk;
    logic        rst;
    logic        sctrl_en;
    logic        sctrl_clear;
    logic [5:0]  sctrl_addr;
    logic [31:0] sctrl_out;
    logic        sctrl_interrupt;
    logic        sensor_ready;
    logic [31:0] sensor_out;
    logic        sensor_en;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: buffer image, fill count and two mode flags.
    logic [31:0] m_mem   [64];
    bit          m_valid [64];
    int          m_cnt;
    bit          m_cap;
    bit          m_full;
    logic [31:0] exp_out;
    bit          exp_out_known;

    sensor_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .sctrl_en        (sctrl_en),
        .sctrl_clear     (sctrl_clear),
        .sctrl_addr      (sctrl_addr),
        .sctrl_out       (sctrl_out),
        .sctrl_interrupt (sctrl_interrupt),
        .sensor_ready    (sensor_ready),
        .sensor_out      (sensor_out),
        .sensor_en       (sensor_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one edge's worth of inputs to the model.
    task automatic model_step(input bit r, input bit en, input bit clr, input bit rdy,
                              input logic [31:0] d, input int a);
        if (r) begin
            m_cap = 1'b0; m_full = 1'b0; m_cnt = 0;
            exp_out = 32'd0; exp_out_known = 1'b1;
        end else begin
            exp_out       = m_mem[a];
            exp_out_known = m_valid[a];
            if (clr) begin
                m_cnt = 0; m_full = 1'b0; m_cap = 1'b0;
            end else if (m_full) begin
                m_cnt = 0;
            end else if (m_cap) begin
                if (rdy) begin
                    m_mem[m_cnt]   = d;
                    m_valid[m_cnt] = 1'b1;
                    m_cnt++;
                    if (m_cnt == 64) begin
                        m_full = 1'b1; m_cap = 1'b0; m_cnt = 0;
                    end
                end else if (!en) begin
                    m_cap = 1'b0;
                end
            end else if (en) begin
                m_cap = 1'b1;
            end
        end
    endtask

    // Drive inputs, take one clock edge, then compare outputs 1 time unit later.
    task automatic cycle(input bit r, input bit en, input bit clr, input bit rdy,
                         input logic [31:0] d, input logic [5:0] a);
        rst = r; sctrl_en = en; sctrl_clear = clr; sensor_ready = rdy;
        sensor_out = d; sctrl_addr = a;
        @(posedge clk);
        model_step(r, en, clr, rdy, d, int'(a));
        #1;
        check_eq("sensor_en", {31'd0, sensor_en}, {31'd0, m_cap});
        check_eq("interrupt", {31'd0, sctrl_interrupt}, {31'd0, m_full});
        if (exp_out_known) begin
            check_eq("sctrl_out", sctrl_out, exp_out);
        end
    endtask

    logic [31:0] old_val;
    bit          old_known;

    initial begin
        for (int i = 0; i < 64; i++) begin
            m_mem[i] = 32'd0; m_valid[i] = 1'b0;
        end
        m_cnt = 0; m_cap = 1'b0; m_full = 1'b0;
        exp_out = 32'd0; exp_out_known = 1'b0;
        rst = 1'b1; sctrl_en = 1'b1; sctrl_clear = 1'b0; sensor_ready = 1'b0;
        sensor_out = 32'd0; sctrl_addr = 6'd0;
        #1;

        // 1: reset held two cycles with enable high
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 6'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 6'd0);
        check_eq("rst_sensor_en", {31'd0, sensor_en}, 32'd0);
        check_eq("rst_irq", {31'd0, sctrl_interrupt}, 32'd0);
        check_eq("rst_out", sctrl_out, 32'd0);

        // 2: fill the buffer, then read every slot back
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'd0);
        for (int i = 0; i < 64; i++) begin
            if (i == 63) check_eq("fill_irq_early", {31'd0, sctrl_interrupt}, 32'd0);
            cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h100 + i, 6'd0);
        end
        check_eq("fill_irq", {31'd0, sctrl_interrupt}, 32'd1);
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'(i));
            check_eq("fill_read", sctrl_out, 32'h100 + i);
        end

        // 3: overflow attempts while full
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD, 6'd0);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'd0);
        check_eq("ovf_buf0", sctrl_out, 32'h100);
        check_eq("ovf_sensor_en", {31'd0, sensor_en}, 32'd0);
        check_eq("ovf_irq", {31'd0, sctrl_interrupt}, 32'd1);

        // 4: clear racing a sample at wr_cnt=10
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 6'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'd0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h200 + i, 6'd0);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hBEEF, 6'd10);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'd10);
        check_eq("race_buf10", sctrl_out, 32'h10A);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h77, 6'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'd0);
        check_eq("race_idx0", sctrl_out, 32'h77);

        // 5: pause after 20 samples, resume for the remaining 44
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 6'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'd0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h400 + i, 6'd0);
        for (int i = 0; i < 5; i++)  cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 6'd0);
        check_eq("pause_sensor_en", {31'd0, sensor_en}, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'd0);
        for (int i = 20; i < 64; i++) begin
            check_eq("pause_irq_early", {31'd0, sctrl_interrupt}, 32'd0);
            cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h400 + i, 6'd0);
        end
        check_eq("pause_irq", {31'd0, sctrl_interrupt}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'd20);
        check_eq("pause_idx20", sctrl_out, 32'h414);

        // 6: read/write collision on index 7
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 6'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'd0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h300 + i, 6'd0);
        old_val = m_mem[7];
        old_known = m_valid[7];
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h55, 6'd7);
        if (old_known) check_eq("coll_old", sctrl_out, old_val);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'd7);
        check_eq("coll_new", sctrl_out, 32'h55);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 500) == 0, ($urandom % 8) != 0, ($urandom % 100) == 0,
                  ($urandom % 2) == 1, $urandom, 6'($urandom % 64));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
